// File: rtl/banked_image_memory.sv
// Flat pixel address space mapped onto NUM_BANKS equal-depth RAM banks, with a
// fixed-latency request pipeline and a fill engine that writes all banks in parallel.
module banked_image_memory #(
   parameter int DATA_W     = 8,
   parameter int BANK_DEPTH = 40000,
   parameter int NUM_BANKS  = 4,
   parameter int ADDR_W     = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done
);
   localparam int OFF_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [ADDR_W:0]  TOTAL = (ADDR_W+1)'(NUM_BANKS * BANK_DEPTH);
   localparam logic [OFF_W-1:0] LAST  = OFF_W'(BANK_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t            state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] fval_q, fval_d;

   logic              accept;
   logic [BANK_W-1:0] dec_bank;
   logic [ADDR_W-1:0] dec_base;
   logic [OFF_W-1:0]  dec_off;
   logic              dec_err;

   logic              s1_valid, s1_we, s1_err;
   logic [BANK_W-1:0] s1_bank;
   logic [OFF_W-1:0]  s1_off;
   logic [DATA_W-1:0] s1_wdata;

   logic              s2_valid, s2_we, s2_err;
   logic [BANK_W-1:0] s2_bank;

   logic [NUM_BANKS*DATA_W-1:0] rd_all;

   assign req_ready = (state_q == IDLE);
   assign fill_busy = (state_q == FILL);
   assign fill_done = (state_q == DONE);
   assign accept    = req_valid && req_ready;

   // Bank decode by comparison against constant bank bases; no divider needed.
   always_comb begin
      dec_bank = '0;
      dec_base = '0;
      for (int unsigned b = 1; b < NUM_BANKS; b++) begin
         if (req_addr >= ADDR_W'(b * BANK_DEPTH)) begin
            dec_bank = BANK_W'(b);
            dec_base = ADDR_W'(b * BANK_DEPTH);
         end
      end
   end

   assign dec_off = OFF_W'(req_addr - dec_base);
   assign dec_err = ({1'b0, req_addr} >= TOTAL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fval_d  = fval_q;
      case (state_q)
         IDLE: begin
            if (fill_start) begin
               state_d = FILL;
               cnt_d   = '0;
               fval_d  = fill_value;
            end
         end
         FILL: begin
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fval_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fval_q  <= fval_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_we    <= 1'b0;
         s1_err   <= 1'b0;
         s1_bank  <= '0;
         s1_off   <= '0;
         s1_wdata <= '0;
      end else begin
         s1_valid <= accept;
         s1_we    <= req_we;
         s1_err   <= dec_err;
         s1_bank  <= dec_bank;
         s1_off   <= dec_off;
         s1_wdata <= req_wdata;
      end
   end

   // A request write and the first fill write can land on the same edge; the
   // fill write is issued last so it takes precedence at a shared offset.
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_W-1:0] mem [BANK_DEPTH];
      logic [DATA_W-1:0] rd_q;
      logic              sel;

      assign sel = s1_valid && !s1_err && (s1_bank == BANK_W'(g));

      always_ff @(posedge clk) begin
         if (sel && s1_we) begin
            mem[s1_off] <= s1_wdata;
         end
         if (state_q == FILL) begin
            mem[cnt_q] <= fval_q;
         end
         if (sel && !s1_we) begin
            rd_q <= mem[s1_off];
         end
      end

      assign rd_all[g*DATA_W +: DATA_W] = rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_we     <= 1'b0;
         s2_err    <= 1'b0;
         s2_bank   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         s2_valid  <= s1_valid;
         s2_we     <= s1_we;
         s2_err    <= s1_err;
         s2_bank   <= s1_bank;
         rsp_valid <= s2_valid;
         rsp_err   <= s2_valid && s2_err;
         rsp_data  <= (s2_valid && !s2_we && !s2_err) ?
                      rd_all[int'(s2_bank)*DATA_W +: DATA_W] : '0;
      end
   end

endmodule

// File: tb/tb_banked_image_memory.sv
// Bench for banked_image_memory: a default-size instance for address mapping and
// pipeline behaviour, and a 16-deep instance for the fill engine and reset cases.
module tb_banked_image_memory;
   localparam int NB = 4;
   localparam int DA = 40000;
   localparam int DB = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_n, req_valid, req_we, fill_start;
   logic [1:0]  req_ready, rsp_valid, rsp_err, fill_busy, fill_done;
   logic [17:0] req_addr [2];
   logic [7:0]  req_wdata [2];
   logic [7:0]  fill_value [2];
   logic [7:0]  rsp_data [2];

   banked_image_memory #(.DATA_W(8), .BANK_DEPTH(DA), .NUM_BANKS(NB), .ADDR_W(18)) dut_a (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
      .fill_start(fill_start[0]), .fill_value(fill_value[0]),
      .fill_busy(fill_busy[0]), .fill_done(fill_done[0]));

   banked_image_memory #(.DATA_W(8), .BANK_DEPTH(DB), .NUM_BANKS(NB), .ADDR_W(6)) dut_b (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1][5:0]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
      .fill_start(fill_start[1]), .fill_value(fill_value[1]),
      .fill_busy(fill_busy[1]), .fill_done(fill_done[1]));

   typedef struct {
      int         inst;
      longint     due;
      logic [7:0] data;
      logic       err;
      logic       lit_en;
      logic [7:0] lit;
   } exp_t;

   longint     cyc = 0;
   longint     fs [2];
   logic [7:0] fv [2];
   logic [7:0] mm [longint];
   exp_t       expq [$];
   logic [1:0] lit_en;
   logic [7:0] lit_val [2];
   int         checks = 0;
   int         errors = 0;
   int         lo_cnt [2];
   int         busy_cnt [2];
   int         done_cnt [2];

   function automatic int depth(int i);
      return (i == 0) ? DA : DB;
   endfunction

   function automatic longint key(int i, longint a);
      return longint'(i) * 1000000 + a;
   endfunction

   task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, exp);
      end
   endtask

   // Model: a fill started at edge S owns edges S+1..S+D (one offset per edge),
   // plus one DONE cycle; requests are only taken outside that window.
   always @(posedge clk) begin : model
      longint     dprev, k;
      logic       rdy, err;
      logic [7:0] v;
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst_n[i]) begin
            dprev = cyc - 1 - fs[i];
            rdy   = (fs[i] < 0) || !(dprev >= 0 && dprev <= depth(i));
            k     = cyc - fs[i] - 1;
            if (fs[i] >= 0 && k >= 0 && k < depth(i)) begin
               for (int b = 0; b < NB; b++) mm[key(i, b * depth(i) + k)] = fv[i];
            end
            if (req_valid[i] && rdy) begin
               err = (req_addr[i] >= NB * depth(i));
               v   = (err || req_we[i]) ? 8'h00 : mm[key(i, req_addr[i])];
               expq.push_back('{i, cyc + 2, v, err, lit_en[i], lit_val[i]});
               if (req_we[i] && !err) mm[key(i, req_addr[i])] = req_wdata[i];
            end
            if (fill_start[i] && rdy) begin
               fs[i] = cyc;
               fv[i] = fill_value[i];
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      longint d;
      int     idx;
      logic   ev, eb, ed;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            chk("reset_outputs", i, {rsp_valid[i], rsp_err[i], fill_busy[i], fill_done[i], rsp_data[i]}, 32'h0);
            fs[i] = -1;
            for (int j = expq.size() - 1; j >= 0; j--) begin
               if (expq[j].inst == i) expq.delete(j);
            end
         end else begin
            d  = cyc - fs[i];
            eb = (fs[i] >= 0) && (d >= 0) && (d < depth(i));
            ed = (fs[i] >= 0) && (d == depth(i));
            chk("fill_busy", i, fill_busy[i], eb);
            chk("fill_done", i, fill_done[i], ed);
            chk("req_ready", i, req_ready[i], !(eb || ed));
            if (!req_ready[i]) lo_cnt[i]++;
            if (fill_busy[i])  busy_cnt[i]++;
            if (fill_done[i])  done_cnt[i]++;
            idx = -1;
            for (int j = 0; j < expq.size(); j++) begin
               if (idx < 0 && expq[j].inst == i) idx = j;
            end
            ev = (idx >= 0) && (expq[idx].due == cyc);
            chk("rsp_valid", i, rsp_valid[i], ev);
            if (ev) begin
               chk("rsp_data", i, rsp_data[i], expq[idx].data);
               chk("rsp_err", i, rsp_err[i], expq[idx].err);
               if (expq[idx].lit_en) chk("rsp_literal", i, rsp_data[i], expq[idx].lit);
               expq.delete(idx);
            end
         end
      end
   end

   task automatic req(int i, logic we, int addr, logic [7:0] wd, logic le, logic [7:0] lv);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = 18'(addr);
      req_wdata[i] = wd;
      lit_en[i]    = le;
      lit_val[i]   = lv;
      @(posedge clk);
      #2;
      req_valid[i] = 1'b0;
      lit_en[i]    = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_tallies(int i);
      lo_cnt[i]   = 0;
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
   endtask

   task automatic wait_done(int i);
      for (int n = 0; n < 200 && done_cnt[i] == 0; n++) @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n      = 2'b00;
      req_valid  = 2'b00;
      req_we     = 2'b00;
      fill_start = 2'b00;
      lit_en     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         fs[i] = -1;
         fv[i] = 8'h00;
         req_addr[i] = '0;
         req_wdata[i] = '0;
         fill_value[i] = '0;
         lit_val[i] = '0;
         clear_tallies(i);
      end
      repeat (3) @(posedge clk);
      #2;
      rst_n = 2'b11;
      #1;
      chk("ready_after_reset", 0, req_ready[0], 1'b1);
      chk("ready_after_reset", 1, req_ready[1], 1'b1);
      #1;

      // Default geometry: bank boundaries, out-of-range, RAW
      req(0, 1, 39999, 8'hA5, 0, 0);
      req(0, 1, 40000, 8'h5A, 0, 0);
      req(0, 0, 39999, 8'h00, 1, 8'hA5);
      req(0, 0, 40000, 8'h00, 1, 8'h5A);
      req(0, 1, 0, 8'h01, 0, 0);
      req(0, 1, 80000, 8'h03, 0, 0);
      req(0, 1, 120000, 8'h04, 0, 0);
      req(0, 1, 159999, 8'h66, 0, 0);
      req(0, 0, 160000, 8'h00, 1, 8'h00);
      req(0, 1, 200000, 8'hFF, 0, 0);
      req(0, 0, 0, 8'h00, 1, 8'h01);
      req(0, 0, 40000, 8'h00, 1, 8'h5A);
      req(0, 0, 80000, 8'h00, 1, 8'h03);
      req(0, 0, 120000, 8'h00, 1, 8'h04);
      req(0, 0, 159999, 8'h00, 1, 8'h66);
      req(0, 1, 120005, 8'h11, 0, 0);
      req(0, 0, 120005, 8'h00, 1, 8'h11);
      idle(4);

      // Small geometry: full fill, with an ignored fill_start mid-fill
      req(1, 1, 5, 8'h77, 0, 0);
      req(1, 1, 31, 8'hAA, 0, 0);
      req(1, 1, 63, 8'hBB, 0, 0);
      idle(1);
      clear_tallies(1);
      fill_start[1] = 1'b1;
      fill_value[1] = 8'h3C;
      @(posedge clk);
      #2;
      fill_start[1] = 1'b0;
      idle(3);
      fill_start[1] = 1'b1;
      fill_value[1] = 8'h99;
      @(posedge clk);
      #2;
      fill_start[1] = 1'b0;
      wait_done(1);
      idle(2);
      chk("fill_busy_cycles", 1, busy_cnt[1], 16);
      chk("ready_low_cycles", 1, lo_cnt[1], 17);
      chk("fill_done_pulses", 1, done_cnt[1], 1);
      req(1, 0, 0, 8'h00, 1, 8'h3C);
      req(1, 0, 31, 8'h00, 1, 8'h3C);
      req(1, 0, 63, 8'h00, 1, 8'h3C);
      idle(3);

      // Read and fill_start in the same IDLE cycle
      req(1, 1, 5, 8'h77, 0, 0);
      clear_tallies(1);
      fill_start[1] = 1'b1;
      fill_value[1] = 8'h00;
      req(1, 0, 5, 8'h00, 1, 8'h77);
      fill_start[1] = 1'b0;
      wait_done(1);
      idle(2);
      chk("fill_done_pulses_2", 1, done_cnt[1], 1);
      req(1, 0, 5, 8'h00, 1, 8'h00);
      idle(3);

      // Reset while the fill counter sits at 8
      req(1, 1, 7, 8'hDD, 0, 0);
      req(1, 1, 8, 8'hEE, 0, 0);
      req(1, 1, 15, 8'hEE, 0, 0);
      req(1, 1, 24, 8'h12, 0, 0);
      idle(1);
      clear_tallies(1);
      fill_start[1] = 1'b1;
      fill_value[1] = 8'h5C;
      @(posedge clk);
      #2;
      fill_start[1] = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n[1] = 1'b0;
      #1;
      chk("reset_immediate", 1, {rsp_valid[1], rsp_err[1], fill_busy[1], fill_done[1], rsp_data[1]}, 32'h0);
      idle(2);
      rst_n[1] = 1'b1;
      #1;
      chk("ready_after_abort", 1, req_ready[1], 1'b1);
      idle(30);
      chk("no_done_after_abort", 1, done_cnt[1], 0);
      req(1, 0, 7, 8'h00, 1, 8'h5C);
      req(1, 0, 8, 8'h00, 1, 8'hEE);
      req(1, 0, 15, 8'h00, 1, 8'hEE);
      req(1, 0, 24, 8'h00, 1, 8'h12);
      req(1, 0, 0, 8'h00, 1, 8'h5C);
      req(1, 0, 16, 8'h00, 1, 8'h5C);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/banked_image_memory.md
# banked_image_memory

Parametrised, pipelined successor to the fixed four-bank image memory controller: maps a flat pixel address space onto `NUM_BANKS` equal-depth RAM banks. Adds a valid/ready request port, a fixed-latency response with out-of-range error reporting, and a hardware fill engine that clears or initialises every bank in parallel. Sits between the processor's memory-mapped image region and the image RAMs.

## Interface
- `DATA_W`, 8, pixel width in bits
- `BANK_DEPTH`, 40000, words per bank
- `NUM_BANKS`, 4, number of banks (≥1)
- `ADDR_W`, 18, flat address width; must cover `NUM_BANKS*BANK_DEPTH`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: request can be accepted
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in `ADDR_W`: flat address
- `req_wdata` in `DATA_W`: write data
- `rsp_valid` out 1: response strobe, one per accepted request
- `rsp_data` out `DATA_W`: read data; 0 for writes and errors
- `rsp_err` out 1: address ≥ `NUM_BANKS*BANK_DEPTH`
- `fill_start` in 1: start fill (sampled in IDLE only)
- `fill_value` in `DATA_W`: fill pattern, captured at start
- `fill_busy` out 1: fill in progress
- `fill_done` out 1: one-cycle pulse on fill completion

## Operation
- Accept: `req_valid & req_ready` at a rising edge.
- Decode (combinational, stage 0): bank = largest b with `req_addr ≥ b*BANK_DEPTH`; offset = `req_addr − bank*BANK_DEPTH`, `clog2(BANK_DEPTH)` bits; err if address ≥ `NUM_BANKS*BANK_DEPTH`. No divider.
- Stage 1 register: valid, we, bank, offset, wdata, err. Bank access on the next edge: a write enables only the selected bank; a read does a synchronous read of the selected bank.
- Stage 2 register: rsp_valid, err, bank select for output mux.
- Errored writes modify no bank. Errored reads return 0.
- Every accepted request, read or write, yields exactly one `rsp_valid` pulse. Responses stay in order. There is no response backpressure.
- Fill FSM states:
  - IDLE → FILL on `fill_start`; `fill_value` captured, counter = 0.
  - FILL: each cycle writes `fill_value` at offset `counter` in all banks simultaneously, then increments the counter. At `counter == BANK_DEPTH−1` the FSM writes and goes to DONE.
  - DONE → IDLE after one cycle.
- `req_ready` = (state == IDLE). `fill_busy` = (state == FILL). `fill_done` = (state == DONE).
- `fill_start` with `req_valid` in the same IDLE cycle: the request is accepted and the fill also starts. The request's bank access occurs on the first FILL-state edge, before any fill write. A read therefore returns pre-fill data.
- `fill_start` outside IDLE is ignored.

## Timing
- Read latency: accept at edge N → `rsp_valid`/`rsp_data` valid after edge N+2, for one cycle.
- Throughput: 1 request per cycle in IDLE.
- Write data is committed at edge N+1. A read accepted at edge N+1 or later sees the new data (back-to-back RAW returns the written value).
- Fill duration: `BANK_DEPTH` cycles in FILL plus 1 in DONE. `req_ready` is low for `BANK_DEPTH+1` cycles.
- Reset (asserted asynchronously, any time):
  - outputs: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `fill_busy`=0, `fill_done`=0
  - internals: state IDLE, counter 0, pipeline valids 0
  - `req_ready`=1 after deassertion; RAM contents are not reset
  - reset mid-fill: the fill is aborted and leaves a partial fill; no `fill_done` is produced
  - reset mid-pipeline: in-flight responses are dropped

## Test plan
- Bank boundary (defaults): write 0xA5 @39999, write 0x5A @40000, read both → 0xA5 then 0x5A; each `rsp_valid` exactly 2 cycles after accept; `rsp_err`=0.
- Out of range: read @160000 → `rsp_err`=1, `rsp_data`=0. Write 0xFF @200000 → `rsp_err`=1; reads of @0, 40000, 80000 and 120000 are unchanged.
- Back-to-back RAW: write 0x11 @120005 at cycle N, read @120005 at N+1 → 0x11 at N+3.
- Fill (`BANK_DEPTH`=16, `NUM_BANKS`=4): `fill_start` with `fill_value`=0x3C → `fill_busy` high 16 cycles, `req_ready` low 17 cycles, one `fill_done` pulse; reads @0, 31, 63 → 0x3C.
- Simultaneous events: 0x77 preloaded @5; read @5 with `fill_start` (value 0x00) in the same cycle → read returns 0x77; after `fill_done`, read @5 → 0x00.
- Reset mid-fill: assert `rst_n`=0 at counter 8 (`BANK_DEPTH`=16) → all outputs 0 immediately; after release `req_ready`=1, no `fill_done`; offsets 0–7 hold the fill value, 8–15 hold old data.
